hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard resolver paired with the 5-stage controller: consumes its hazard
//  indicators (RegWriteM/W, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE) and drives back
//  FlushE plus stage stalls/flushes and E-stage operand forwarding selects.
//  Adds a data-memory wait FSM with timeout, and saturating stall/flush event counters.
// PARAMETERS
//  CNT_W    16  width of StallCount/FlushCount
//  TIMEOUT  64  max consecutive memory-wait cycles before MemTimeout (>=2)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      synchronous, active-high
//  RA1D,RA2D     in   4      D-stage source register numbers
//  RA1E,RA2E     in   4      E-stage source register numbers
//  WA3E,WA3M,WA3W in  4      destination register numbers in E/M/W
//  RegWriteM,RegWriteW in 1  register write enables in M/W (already condition-gated)
//  MemtoRegE     in   1      E-stage instruction is a load
//  PCWrPendingF  in   1      PC write pending in D/E/M
//  PCSrcW        in   1      PC written in W
//  BranchTakenE  in   1      branch resolved taken in E
//  MemReqM       in   1      M-stage instruction accesses data memory
//  MemReadyM     in   1      data memory completes access this cycle
//  ForwardAE,ForwardBE out 2 00=regfile, 01=ResultW, 10=ALUOutM
//  StallF,StallD,StallE,StallM out 1  hold stage register
//  FlushD,FlushE,FlushW out 1 clear stage register (bubble)
//  MemTimeout    out  1      sticky: memory wait exceeded TIMEOUT
//  StallCount    out  CNT_W  cycles with StallF=1, saturating
//  FlushCount    out  CNT_W  cycles with FlushE=1, saturating
// BEHAVIOUR
//  Forwarding (combinational): ForwardAE=10 if RA1E==WA3M & RegWriteM; else 01 if
//   RA1E==WA3W & RegWriteW; else 00. M has priority over W. ForwardBE same with RA2E.
//  ldrStall = (RA1D==WA3E | RA2D==WA3E) & MemtoRegE.
//  memStall = MemReqM & ~MemReadyM & ~MemTimeout.
//  memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (pending
//   flush conditions are held in stalled regs and take effect after release).
//  memStall=0: StallF=ldrStall|PCWrPendingF; StallD=ldrStall; StallE=StallM=FlushW=0;
//   FlushD=PCWrPendingF|PCSrcW|BranchTakenE; FlushE=ldrStall|BranchTakenE.
//  All stall/flush/forward outputs combinational (same-cycle as inputs).
//  Wait FSM, states IDLE/WAIT/ERR; WaitCnt ceil(log2(TIMEOUT))+1 bits:
//   IDLE: MemReqM&~MemReadyM -> WAIT, WaitCnt<=1.
//   WAIT: MemReadyM -> IDLE, WaitCnt<=0; else if WaitCnt==TIMEOUT-1 -> ERR;
//    else WaitCnt<=WaitCnt+1. MemReqM dropping without ready -> IDLE.
//   ERR: MemTimeout=1; stays until reset; memStall forced 0 (pipeline drains).
//  Counters: +1 per cycle StallF (resp. FlushE) is 1; hold at 2^CNT_W-1.
//  Reset (sync, any state incl. mid-wait): FSM=IDLE, WaitCnt=0, MemTimeout=0,
//   counters=0. Combinational outputs follow inputs during reset.
// TESTING
//  RA1E=3,WA3M=3,RegWriteM=1,WA3W=3,RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01.
//  MemtoRegE=1,WA3E=5,RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0; StallCount +1.
//  BranchTakenE=1 alone -> FlushD=FlushE=1, StallF=0; FlushCount +1 per cycle.
//  MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> Stall F/D/E/M + FlushW 3 cycles, IDLE after.
//  TIMEOUT=4, MemReadyM held 0 -> MemTimeout=1 on 4th wait edge, stalls drop; reset clears.
//  Reset asserted in WAIT -> next cycle IDLE, counters 0; CNT_W=2 saturation holds at 3.

Source files
------------

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard resolver for the 5-stage core. It produces the
//               E-stage operand forwarding selects and the load-use and
//               control stalls and flushes. It also holds the pipeline while
//               data memory is not ready, with a timeout. Two saturating
//               counters record stall and flush cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int                    c_WCNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_WCNT_W-1:0]   c_WAIT_LAST = c_WCNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_ERR  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_stateNext;
    logic [c_WCNT_W-1:0] r_waitCnt;
    logic [c_WCNT_W-1:0] w_waitCntNext;
    logic                w_ldrStall;
    logic                w_memStall;
    logic [CNT_W-1:0]    r_stallCount;
    logic [CNT_W-1:0]    r_flushCount;

    // After a timeout the memory stall is released so that the pipeline can drain.
    assign MemTimeout = (r_state == c_S_ERR);
    assign w_ldrStall = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE;
    assign w_memStall = MemReqM && !MemReadyM && !MemTimeout;
    assign StallCount = r_stallCount;
    assign FlushCount = r_flushCount;

    // Operand forwarding. The M stage holds the younger result, so it takes priority over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
        else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
        if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
        else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
    end

    // Stall and flush selection. A memory stall freezes F through M, and a
    // bubble enters W. Any pending flush stays in the frozen registers.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (w_memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = w_ldrStall || PCWrPendingF;
            StallD = w_ldrStall;
            FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
            FlushE = w_ldrStall || BranchTakenE;
        end
    end

    // Memory-wait FSM: next state and wait count.
    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = r_waitCnt;
        case (r_state)
            c_S_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    w_stateNext   = c_S_WAIT;
                    w_waitCntNext = c_WCNT_W'(1);
                end
            end
            c_S_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    w_stateNext   = c_S_IDLE;
                    w_waitCntNext = '0;
                end else if (r_waitCnt == c_WAIT_LAST) begin
                    w_stateNext   = c_S_ERR;
                    w_waitCntNext = '0;
                end else begin
                    w_waitCntNext = r_waitCnt + c_WCNT_W'(1);
                end
            end
            c_S_ERR: begin
                w_stateNext   = c_S_ERR;
                w_waitCntNext = '0;
            end
            default: begin
                w_stateNext   = c_S_IDLE;
                w_waitCntNext = '0;
            end
        endcase
    end

    // Memory-wait FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
        end
    end

    // Saturating event counters. Each counter stops at its all-ones value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (StallF && (r_stallCount != '1)) r_stallCount <= r_stallCount + 1'b1;
            if (FlushE && (r_flushCount != '1)) r_flushCount <= r_flushCount + 1'b1;
        end
    end

endmodule
`default_nettype wire
